// File: rtl/vec_alu_fu.sv
// Segmented SIMD add/sub unit: lanes are grouped into 2^mode-lane segments, each an independent wide op.
// Latency: start sampled at edge N -> result registered at N+1, res_valid at N+2; result held until res_rdy.
module vec_alu_fu #(
    parameter int LANE_W    = 16,
    parameter int NUM_LANES = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        cfg_wr_en,
    output logic                        cfg_wr_rdy,
    input  logic [NUM_LANES*LANE_W-1:0] cfg_wr_a,
    input  logic [NUM_LANES*LANE_W-1:0] cfg_wr_b,
    input  logic [1:0]                  cfg_wr_mode,
    input  logic [1:0]                  cfg_wr_op,
    output logic                        cfg_wr_ack,
    input  logic                        start,
    output logic                        res_valid,
    output logic [NUM_LANES*LANE_W-1:0] res_data,
    output logic [NUM_LANES-1:0]        res_flag,
    input  logic                        res_rdy,
    output logic                        busy,
    output logic                        err
);
    localparam int W = NUM_LANES * LANE_W;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] EXEC   = 2'd1;
    localparam logic [1:0] RESULT = 2'd2;

    logic [1:0]           state_q, state_d;
    logic                 loaded_q, loaded_d;
    logic [W-1:0]         a_q, a_d, b_q, b_d;
    logic [1:0]           mode_q, mode_d, op_q, op_d;
    logic                 cfg_wr_rdy_q, cfg_wr_rdy_d;
    logic                 cfg_wr_ack_q, cfg_wr_ack_d;
    logic                 res_valid_q, res_valid_d;
    logic [W-1:0]         res_data_q, res_data_d;
    logic [NUM_LANES-1:0] res_flag_q, res_flag_d;
    logic                 busy_q, busy_d;
    logic                 err_q, err_d;

    logic [W-1:0]         raw;
    logic [W-1:0]         alu_data;
    logic [NUM_LANES-1:0] alu_flag;
    logic [NUM_LANES-1:0] top_ovf;
    logic                 wr_fire;
    logic                 mode_legal;

    // Lane-serial ripple; the carry is re-seeded at each segment's lowest lane so nothing crosses segments.
    always_comb begin
        int          seg_mask;
        logic        is_sub;
        logic        carry;
        logic        ovf;
        logic [LANE_W-1:0] opb;
        logic [LANE_W:0]   sum;
        seg_mask = (1 << mode_q) - 1;
        is_sub   = op_q[0];
        carry    = 1'b0;
        ovf      = 1'b0;
        opb      = '0;
        sum      = '0;
        raw      = '0;
        top_ovf  = '0;
        alu_data = '0;
        alu_flag = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if ((i & seg_mask) == 0) carry = is_sub;
            opb = is_sub ? ~b_q[i*LANE_W +: LANE_W] : b_q[i*LANE_W +: LANE_W];
            sum = {1'b0, a_q[i*LANE_W +: LANE_W]} + {1'b0, opb} + {{LANE_W{1'b0}}, carry};
            raw[i*LANE_W +: LANE_W] = sum[LANE_W-1:0];
            carry = sum[LANE_W];
            // Subtraction is A + ~B + 1, so a borrow shows up as a missing carry-out.
            if ((i & seg_mask) == seg_mask) top_ovf[i] = carry ^ is_sub;
        end
        for (int i = NUM_LANES - 1; i >= 0; i--) begin
            if ((i & seg_mask) == seg_mask) begin
                ovf         = top_ovf[i];
                alu_flag[i] = ovf;
            end
            alu_data[i*LANE_W +: LANE_W] = raw[i*LANE_W +: LANE_W];
            if (op_q[1] && ovf) alu_data[i*LANE_W +: LANE_W] = is_sub ? '0 : '1;
        end
    end

    assign wr_fire    = cfg_wr_en && cfg_wr_rdy_q;
    assign mode_legal = ((1 << mode_q) <= NUM_LANES);

    always_comb begin
        state_d      = state_q;
        loaded_d     = loaded_q;
        a_d          = a_q;
        b_d          = b_q;
        mode_d       = mode_q;
        op_d         = op_q;
        cfg_wr_ack_d = 1'b0;
        err_d        = 1'b0;
        res_valid_d  = res_valid_q;
        res_data_d   = res_data_q;
        res_flag_d   = res_flag_q;
        case (state_q)
            IDLE: begin
                if (wr_fire) begin
                    a_d          = cfg_wr_a;
                    b_d          = cfg_wr_b;
                    mode_d       = cfg_wr_mode;
                    op_d         = cfg_wr_op;
                    loaded_d     = 1'b1;
                    cfg_wr_ack_d = 1'b1;
                end else if (start) begin
                    if (loaded_q && mode_legal) state_d = EXEC;
                    else                        err_d   = 1'b1;
                end
            end
            EXEC: begin
                res_data_d = alu_data;
                res_flag_d = alu_flag;
                state_d    = RESULT;
            end
            RESULT: begin
                if (res_valid_q && res_rdy) begin
                    res_valid_d = 1'b0;
                    state_d     = IDLE;
                end else begin
                    res_valid_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d       = (state_d != IDLE);
        cfg_wr_rdy_d = (state_d == IDLE) && !cfg_wr_ack_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            loaded_q     <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            mode_q       <= '0;
            op_q         <= '0;
            cfg_wr_rdy_q <= 1'b0;
            cfg_wr_ack_q <= 1'b0;
            res_valid_q  <= 1'b0;
            res_data_q   <= '0;
            res_flag_q   <= '0;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            loaded_q     <= loaded_d;
            a_q          <= a_d;
            b_q          <= b_d;
            mode_q       <= mode_d;
            op_q         <= op_d;
            cfg_wr_rdy_q <= cfg_wr_rdy_d;
            cfg_wr_ack_q <= cfg_wr_ack_d;
            res_valid_q  <= res_valid_d;
            res_data_q   <= res_data_d;
            res_flag_q   <= res_flag_d;
            busy_q       <= busy_d;
            err_q        <= err_d;
        end
    end

    assign cfg_wr_rdy = cfg_wr_rdy_q;
    assign cfg_wr_ack = cfg_wr_ack_q;
    assign res_valid  = res_valid_q;
    assign res_data   = res_data_q;
    assign res_flag   = res_flag_q;
    assign busy       = busy_q;
    assign err        = err_q;
endmodule

// File: tb/tb_vec_alu_fu.sv
// Directed bench for vec_alu_fu (LANE_W=16, NUM_LANES=4) with hand-computed expectations.
module tb_vec_alu_fu;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cfg_wr_en = 1'b0;
    logic        cfg_wr_rdy;
    logic [63:0] cfg_wr_a = '0;
    logic [63:0] cfg_wr_b = '0;
    logic [1:0]  cfg_wr_mode = '0;
    logic [1:0]  cfg_wr_op = '0;
    logic        cfg_wr_ack;
    logic        start = 1'b0;
    logic        res_valid;
    logic [63:0] res_data;
    logic [3:0]  res_flag;
    logic        res_rdy = 1'b0;
    logic        busy;
    logic        err;

    int total = 0;
    int bad   = 0;

    vec_alu_fu #(.LANE_W(16), .NUM_LANES(4)) dut (
        .clk(clk), .reset(reset),
        .cfg_wr_en(cfg_wr_en), .cfg_wr_rdy(cfg_wr_rdy),
        .cfg_wr_a(cfg_wr_a), .cfg_wr_b(cfg_wr_b),
        .cfg_wr_mode(cfg_wr_mode), .cfg_wr_op(cfg_wr_op), .cfg_wr_ack(cfg_wr_ack),
        .start(start), .res_valid(res_valid), .res_data(res_data), .res_flag(res_flag),
        .res_rdy(res_rdy), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input logic [63:0] a, input logic [63:0] b,
                            input logic [1:0] m, input logic [1:0] o);
        logic got;
        got = 1'b0;
        cfg_wr_a = a; cfg_wr_b = b; cfg_wr_mode = m; cfg_wr_op = o;
        cfg_wr_en = 1'b1;
        for (int k = 0; k < 8 && !got; k++) begin
            tick();
            if (cfg_wr_ack) got = 1'b1;
        end
        cfg_wr_en = 1'b0;
        chk("wr_ack_seen", {63'd0, got}, 64'd1);
        chk("wr_rdy_low_in_ack", {63'd0, cfg_wr_rdy}, 64'd0);
        tick();
    endtask

    // Start sampled at edge N; valid must be absent after N and N+1, present after N+2.
    task automatic exec_check(input string tag, input logic [63:0] exp_data, input logic [3:0] exp_flag);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, "_busy"}, {63'd0, busy}, 64'd1);
        chk({tag, "_vld_n0"}, {63'd0, res_valid}, 64'd0);
        tick();
        chk({tag, "_vld_n1"}, {63'd0, res_valid}, 64'd0);
        tick();
        chk({tag, "_vld_n2"}, {63'd0, res_valid}, 64'd1);
        chk({tag, "_data"}, res_data, exp_data);
        chk({tag, "_flag"}, {60'd0, res_flag}, {60'd0, exp_flag});
        res_rdy = 1'b1;
        tick();
        res_rdy = 1'b0;
        chk({tag, "_vld_drop"}, {63'd0, res_valid}, 64'd0);
        chk({tag, "_idle"}, {63'd0, busy}, 64'd0);
        chk({tag, "_rdy_back"}, {63'd0, cfg_wr_rdy}, 64'd1);
    endtask

    initial begin
        #2;
        chk("rst_rdy", {63'd0, cfg_wr_rdy}, 64'd0);
        chk("rst_ack", {63'd0, cfg_wr_ack}, 64'd0);
        chk("rst_vld", {63'd0, res_valid}, 64'd0);
        chk("rst_data", res_data, 64'd0);
        chk("rst_flag", {60'd0, res_flag}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_err", {63'd0, err}, 64'd0);
        tick();
        tick();
        reset = 1'b1;
        chk("rdy_before_edge", {63'd0, cfg_wr_rdy}, 64'd0);
        tick();
        chk("rdy_after_edge", {63'd0, cfg_wr_rdy}, 64'd1);

        // start before any write: err pulse, no execution
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("unloaded_err", {63'd0, err}, 64'd1);
        chk("unloaded_busy", {63'd0, busy}, 64'd0);
        tick();
        chk("unloaded_err_drop", {63'd0, err}, 64'd0);

        // mode 0 add: lanes independent, carries out of lanes 0 and 2
        do_write(64'h1234_8000_0005_FFFF, 64'h0001_8000_0003_0001, 2'd0, 2'b00);
        exec_check("m0_add", 64'h1235_0000_0008_0000, 4'b0101);

        // mode 1 add: carry ripples lane0->lane1, upper segment wraps with carry-out
        do_write(64'hFFFF_FFFF_0000_FFFF, 64'h0000_0002_0000_0001, 2'd1, 2'b00);
        exec_check("m1_add", 64'h0000_0001_0001_0000, 4'b1000);

        // mode 2 sub 0-1 wraps to all ones with borrow
        do_write(64'h0, 64'h1, 2'd2, 2'b01);
        exec_check("m2_sub", 64'hFFFF_FFFF_FFFF_FFFF, 4'b1000);

        // mode 0 saturating add
        do_write(64'hFFFF_8000_0001_FFF0, 64'h0001_7FFF_0002_0020, 2'd0, 2'b10);
        exec_check("m0_sadd", 64'hFFFF_FFFF_0003_FFFF, 4'b1001);

        // mode 0 saturating sub
        do_write(64'h0000_0005_0020_0010, 64'hFFFF_0005_0010_0020, 2'd0, 2'b11);
        exec_check("m0_ssub", 64'h0000_0000_0010_0000, 4'b1001);

        // mode 1 saturating sub: lower segment clamps, upper borrows internally only
        do_write(64'h0001_0000_0000_0005, 64'h0000_0001_0000_0006, 2'd1, 2'b11);
        exec_check("m1_ssub", 64'h0000_FFFF_0000_0000, 4'b0010);
        // configuration reused without a new write
        exec_check("m1_ssub_again", 64'h0000_FFFF_0000_0000, 4'b0010);

        // illegal mode (8 lanes > 4): err pulse, stays idle
        do_write(64'h1, 64'h1, 2'd3, 2'b00);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("illegal_err", {63'd0, err}, 64'd1);
        chk("illegal_busy", {63'd0, busy}, 64'd0);
        tick();
        chk("illegal_err_drop", {63'd0, err}, 64'd0);

        // write and start in the same cycle: write wins, no err, no exec
        cfg_wr_a = 64'h0000_0000_0000_0007; cfg_wr_b = 64'h0000_0000_0000_0003;
        cfg_wr_mode = 2'd0; cfg_wr_op = 2'b01;
        cfg_wr_en = 1'b1;
        start = 1'b1;
        tick();
        cfg_wr_en = 1'b0;
        start = 1'b0;
        chk("wr_win_ack", {63'd0, cfg_wr_ack}, 64'd1);
        chk("wr_win_err", {63'd0, err}, 64'd0);
        chk("wr_win_busy", {63'd0, busy}, 64'd0);
        tick();

        // hold RESULT with res_rdy low while start/cfg_wr_en are pushed
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("hold_vld0", {63'd0, res_valid}, 64'd1);
        chk("hold_data0", res_data, 64'h0000_0000_0000_0004);
        start = 1'b1;
        cfg_wr_en = 1'b1;
        cfg_wr_a = 64'hDEAD_BEEF_DEAD_BEEF;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("hold_vld", {63'd0, res_valid}, 64'd1);
            chk("hold_data", res_data, 64'h0000_0000_0000_0004);
            chk("hold_busy", {63'd0, busy}, 64'd1);
            chk("hold_rdy", {63'd0, cfg_wr_rdy}, 64'd0);
            chk("hold_ack", {63'd0, cfg_wr_ack}, 64'd0);
        end
        start = 1'b0;
        cfg_wr_en = 1'b0;
        res_rdy = 1'b1;
        tick();
        res_rdy = 1'b0;
        chk("hold_release_vld", {63'd0, res_valid}, 64'd0);
        chk("hold_release_busy", {63'd0, busy}, 64'd0);
        // the ignored write must not have replaced operand A
        exec_check("hold_cfg_kept", 64'h0000_0000_0000_0004, 4'b0000);

        // reset asserted mid-EXEC clears outputs immediately
        do_write(64'h0000_0000_0000_FFFF, 64'h1, 2'd0, 2'b00);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("pre_rst_busy", {63'd0, busy}, 64'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("mid_rst_busy", {63'd0, busy}, 64'd0);
        chk("mid_rst_vld", {63'd0, res_valid}, 64'd0);
        chk("mid_rst_rdy", {63'd0, cfg_wr_rdy}, 64'd0);
        chk("mid_rst_data", res_data, 64'd0);
        chk("mid_rst_flag", {60'd0, res_flag}, 64'd0);
        tick();
        chk("in_rst_vld", {63'd0, res_valid}, 64'd0);
        reset = 1'b1;
        tick();
        chk("post_rst_rdy", {63'd0, cfg_wr_rdy}, 64'd1);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("post_rst_err", {63'd0, err}, 64'd1);
        chk("post_rst_busy", {63'd0, busy}, 64'd0);
        tick();
        chk("post_rst_err_drop", {63'd0, err}, 64'd0);
        chk("post_rst_busy2", {63'd0, busy}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/vec_alu_fu.md
VEC_ALU_FU -- requirements
Module: vec_alu_fu

Interface
REQ-001 The block SHALL have parameter LANE_W, default 16, lane width in bits.
REQ-002 The block SHALL have parameter NUM_LANES, default 4, lane count; legal values are powers of 2, 1 to 8.
REQ-003 The block SHALL have a single clock and SHALL use an asynchronous, active-low reset (one clock; reset is asynchronous and active-low).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port cfg_wr_en, input, 1 bit: write request, held high until cfg_wr_ack.
REQ-007 The block SHALL have port cfg_wr_rdy, output, 1 bit: block can accept a write.
REQ-008 The block SHALL have port cfg_wr_a, input, NUM_LANES*LANE_W bits: operand A; lane i occupies bits [i*LANE_W +: LANE_W].
REQ-009 The block SHALL have port cfg_wr_b, input, NUM_LANES*LANE_W bits: operand B, packed the same way as cfg_wr_a.
REQ-010 The block SHALL have port cfg_wr_mode, input, 2 bits: segment size is 2^mode lanes.
REQ-011 The block SHALL have port cfg_wr_op, input, 2 bits: 00 add, 01 sub (A-B), 10 unsigned saturating add, 11 unsigned saturating sub.
REQ-012 The block SHALL have port cfg_wr_ack, output, 1 bit: one-cycle write acknowledge.
REQ-013 The block SHALL have port start, input, 1 bit: execute request.
REQ-014 The block SHALL have port res_valid, output, 1 bit: result valid.
REQ-015 The block SHALL have port res_data, output, NUM_LANES*LANE_W bits: result.
REQ-016 The block SHALL have port res_flag, output, NUM_LANES bits: per-segment carry, borrow or saturation flag.
REQ-017 The block SHALL have port res_rdy, input, 1 bit: consumer accepts the result.
REQ-018 The block SHALL have port busy, output, 1 bit: block is in state EXEC or RESULT.
REQ-019 The block SHALL have port err, output, 1 bit: one-cycle rejected-start pulse.

Function
REQ-020 The block SHALL implement an FSM with states IDLE, EXEC and RESULT; all outputs SHALL be registered.
REQ-021 In IDLE and not in the cycle cfg_wr_ack is high, cfg_wr_rdy SHALL be 1; in all other cases it SHALL be 0.
REQ-022 When cfg_wr_en and cfg_wr_rdy are both high at a rising edge, the block SHALL latch A, B, mode and op, set internal flag loaded=1, and drive cfg_wr_ack=1 for exactly the next cycle.
REQ-023 In IDLE, start=1 with loaded=1 and a legal mode (2^mode <= NUM_LANES) SHALL move the FSM to EXEC.
REQ-024 In IDLE, start=1 with loaded=0 or an illegal mode SHALL pulse err for one cycle, and the FSM SHALL stay in IDLE.
REQ-025 When cfg_wr_en and start are both accepted-eligible in the same IDLE cycle, the write SHALL win, start SHALL be ignored and err SHALL not assert.
REQ-026 The FSM SHALL leave EXEC unconditionally after one cycle, register res_data and res_flag, and enter RESULT.
REQ-027 If start is sampled at edge N, res_valid SHALL be high after edge N+2.
REQ-028 In RESULT, res_valid SHALL stay 1 and res_data and res_flag SHALL stay stable until res_valid and res_rdy are both high at an edge; the FSM SHALL then return to IDLE with res_valid=0.
REQ-029 start and cfg_wr_en SHALL be ignored while the FSM is in EXEC or RESULT.
REQ-030 Each segment SHALL be an independent 2^mode*LANE_W-bit unsigned operation; carries SHALL never cross segment boundaries.
REQ-031 For add and sub, the result SHALL wrap modulo the segment width.
REQ-032 For saturating add, overflow SHALL clamp the segment to all ones; for saturating sub, underflow SHALL clamp the segment to 0.
REQ-033 The res_flag bit at the segment's highest lane index SHALL be the carry-out (add), the borrow (sub) or the saturation-occurred indication (sat ops); all other res_flag bits SHALL be 0.
REQ-034 The latched configuration SHALL persist across executions; repeated starts SHALL reuse it, and loaded SHALL clear only on reset.

Reset
REQ-035 While reset=0, the FSM SHALL be IDLE, loaded SHALL be 0, all internal registers SHALL be 0, and every output (cfg_wr_rdy, cfg_wr_ack, res_valid, res_data, res_flag, busy, err) SHALL be 0.
REQ-036 Reset assertion in any state, including mid-EXEC or mid-RESULT, SHALL abort the operation immediately without waiting for a clock edge.
REQ-037 cfg_wr_rdy SHALL rise at the first clock edge after reset deasserts.

Verification (LANE_W=16, NUM_LANES=4)
REQ-038 Mode 0 add, lane0 A=0xFFFF, B=0x0001 -> res lane0=0x0000, res_flag[0]=1, other lanes correct and independent.
REQ-039 Mode 1 add, A[31:0]=0x0000FFFF, B[31:0]=1 -> res[31:0]=0x00010000, res_flag[1]=0, res_flag[0]=0.
REQ-040 Mode 2 sub, A=0, B=1 -> res_data=all 0xFFFF, res_flag=4'b1000, res_valid exactly 2 edges after start.
REQ-041 Mode 0 sat add 0xFFF0+0x0020 -> 0xFFFF with res_flag[0]=1; mode 0 sat sub 0x0010-0x0020 -> 0x0000 with res_flag[0]=1.
REQ-042 Hold res_rdy=0 for 5 cycles in RESULT -> res_valid, res_data and busy stay stable, cfg_wr_rdy=0, start ignored; res_rdy=1 -> IDLE next cycle.
REQ-043 Assert reset mid-EXEC -> all outputs 0 at once; then start without a write -> single err pulse, busy stays 0.
